// File: rtl/mtimer_compare.sv
// mtimer_compare
// Machine-timer compare and readout block for an RV32 core. It holds the
// 64-bit mtimecmp register behind a 32-bit CSR access port and raises the
// machine timer interrupt (mtip) when the live time count reaches it. It also
// gives tear-free 64-bit time reads: a time_lo read captures the upper half,
// and a later time_hi read returns that captured value.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous, active-low reset
//   time_in    live 64-bit real-time count
//   mtie       timer interrupt enable (mie.MTIE)
//   csr_req    single-cycle access request
//   csr_we     1 = write, 0 = read (qualified by csr_req)
//   csr_sel    0 = cmp_lo, 1 = cmp_hi, 2 = time_lo, 3 = time_hi
//   csr_wdata  write data
//   csr_rdata  registered read data, valid with csr_ack
//   csr_ack    one-cycle completion pulse, one cycle after csr_req
//   mtip       registered machine timer interrupt pending (level)
//
// COUNT_LEN must be 64: the count is accessed as two 32-bit halves.
module mtimer_compare #(
  parameter int                   COUNT_LEN = 64,
  parameter logic [COUNT_LEN-1:0] CMP_RESET = {COUNT_LEN{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COUNT_LEN-1:0] time_in,
  input  logic                 mtie,
  input  logic                 csr_req,
  input  logic                 csr_we,
  input  logic [1:0]           csr_sel,
  input  logic [31:0]          csr_wdata,
  output logic [31:0]          csr_rdata,
  output logic                 csr_ack,
  output logic                 mtip
);

  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [COUNT_LEN-1:0] r_cmp;
  logic [31:0]          r_snap_hi;
  logic [31:0]          r_rdata;
  logic [31:0]          w_rdata_next;
  logic                 r_ack;
  logic                 r_mtip;
  logic                 w_mtip_next;
  logic                 w_wr_lo;
  logic                 w_wr_hi;
  logic                 w_rd_time_lo;

  assign w_wr_lo      = csr_req & csr_we & (csr_sel == 2'd0);
  assign w_wr_hi      = csr_req & csr_we & (csr_sel == 2'd1);
  assign w_rd_time_lo = csr_req & ~csr_we & (csr_sel == 2'd2);

  // Compare register halves; each half is written by its own select code.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cmp_half
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cmp[gi*32 +: 32] <= CMP_RESET[gi*32 +: 32];
      end else if (csr_req && csr_we && (csr_sel == 2'(gi))) begin
        r_cmp[gi*32 +: 32] <= csr_wdata;
      end
    end
  end

  // Only the upper half of the snapshot is ever returned; the lower half is
  // delivered live by the time_lo read that takes the snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_hi <= '0;
    end else if (w_rd_time_lo) begin
      r_snap_hi <= time_in[63:32];
    end
  end

  // Read data: writes echo the written data, reads return the selected
  // source as of the request cycle, idle cycles hold the previous value.
  always_comb begin
    w_rdata_next = r_rdata;
    if (csr_req) begin
      if (csr_we) begin
        w_rdata_next = csr_wdata;
      end else begin
        case (csr_sel)
          2'd0:    w_rdata_next = r_cmp[31:0];
          2'd1:    w_rdata_next = r_cmp[63:32];
          2'd2:    w_rdata_next = time_in[31:0];
          default: w_rdata_next = r_snap_hi;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_rdata <= w_rdata_next;
      r_ack   <= csr_req;
    end
  end

  // Compare FSM. While a new compare value is half written (and during the
  // lo-write cycle itself) mtip is held, so a partially updated register
  // cannot raise or drop the interrupt; mtie = 0 still clears it.
  always_comb begin
    w_state_next = r_state;
    w_mtip_next  = r_mtip & mtie;
    case (r_state)
      ST_ARMED: begin
        if (w_wr_lo) begin
          w_state_next = ST_HALF;
        end else begin
          w_mtip_next = mtie & (time_in >= r_cmp);
        end
      end
      ST_HALF: begin
        if (w_wr_hi) begin
          w_state_next = ST_ARMED;
        end
      end
      default: begin
        w_state_next = ST_ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARMED;
      r_mtip  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mtip  <= w_mtip_next;
    end
  end

  assign csr_rdata = r_rdata;
  assign csr_ack   = r_ack;
  assign mtip      = r_mtip;

endmodule

// File: tb/tb_mtimer_compare.sv
// Directed testbench for mtimer_compare. Inputs change on the falling edge
// and outputs are sampled on the falling edge, half a cycle after the rising
// edge that registered them.
module tb_mtimer_compare;

  logic        clk;
  logic        rst_n;
  logic [63:0] time_in;
  logic        mtie;
  logic        csr_req;
  logic        csr_we;
  logic [1:0]  csr_sel;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ack;
  logic        mtip;

  int checks = 0;
  int errors = 0;

  mtimer_compare #(
    .COUNT_LEN(64),
    .CMP_RESET({64{1'b1}})
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .time_in  (time_in),
    .mtie     (mtie),
    .csr_req  (csr_req),
    .csr_we   (csr_we),
    .csr_sel  (csr_sel),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .csr_ack  (csr_ack),
    .mtip     (mtip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One access: request held for exactly one rising edge; returns at the
  // falling edge where the ack is due.
  task automatic access(input logic we, input logic [1:0] sel, input logic [31:0] wd);
    csr_req   = 1'b1;
    csr_we    = we;
    csr_sel   = sel;
    csr_wdata = wd;
    tick();
    csr_req   = 1'b0;
    csr_we    = 1'b0;
    csr_wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0; time_in = '0; mtie = 1'b0;
    csr_req = 1'b0; csr_we = 1'b0; csr_sel = '0; csr_wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_ack", csr_ack, 0);
    check("rst_rdata", csr_rdata, 0);
    check("rst_mtip", mtip, 0);
    rst_n = 1'b1;

    // cmp is all ones after reset: no interrupt, reads return all ones
    time_in = 64'h0000_0000_0000_1000; mtie = 1'b1;
    tick(); tick();
    check("mtip_after_reset", mtip, 0);
    check("idle_no_ack", csr_ack, 0);
    access(1'b0, 2'd0, '0);
    check("rd_cmp_lo_ack", csr_ack, 1);
    check("rd_cmp_lo_reset", csr_rdata, 32'hFFFF_FFFF);
    tick();
    check("ack_single_pulse", csr_ack, 0);
    access(1'b0, 2'd1, '0);
    check("rd_cmp_hi_ack", csr_ack, 1);
    check("rd_cmp_hi_reset", csr_rdata, 32'hFFFF_FFFF);

    // time_hi before any time_lo read returns 0
    access(1'b0, 2'd3, '0);
    check("rd_time_hi_nosnap", csr_rdata, 0);

    // Split compare write: mtip held while half written
    access(1'b1, 2'd0, 32'h0000_0010);
    check("wr_lo_ack", csr_ack, 1);
    check("wr_lo_rdata", csr_rdata, 32'h0000_0010);
    check("half_mtip_0", mtip, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("half_mtip_idle", mtip, 0);
    end
    access(1'b1, 2'd1, 32'h0);
    check("wr_hi_ack", csr_ack, 1);
    check("wr_hi_ack_mtip", mtip, 0);
    tick();
    check("armed_mtip_rise", mtip, 1);

    // Coherent time read across a carry into the upper half
    time_in = 64'h0000_0001_FFFF_FFFF;
    access(1'b0, 2'd2, '0);
    check("rd_time_lo", csr_rdata, 32'hFFFF_FFFF);
    time_in = 64'h0000_0002_0000_0000;
    access(1'b0, 2'd3, '0);
    check("rd_time_hi_snap", csr_rdata, 32'h0000_0001);

    // cmp = 0x50, sweep time across it
    time_in = 64'h4E;
    access(1'b1, 2'd0, 32'h0000_0050);
    access(1'b1, 2'd1, 32'h0);
    tick(); tick();
    check("sweep_4e", mtip, 0);
    time_in = 64'h4F; tick();
    check("sweep_4f", mtip, 0);
    time_in = 64'h50;
    check("sweep_50_lag", mtip, 0);
    tick();
    check("sweep_50", mtip, 1);
    time_in = 64'h51; tick();
    check("sweep_51", mtip, 1);
    time_in = 64'h52; tick();
    check("sweep_52", mtip, 1);
    mtie = 1'b0; tick();
    check("mtie_clear", mtip, 0);

    // Wrap from all ones to zero drops mtip
    mtie = 1'b1; time_in = {64{1'b1}}; tick();
    check("wrap_high", mtip, 1);
    time_in = '0; tick();
    check("wrap_low", mtip, 0);

    // HALF freezes mtip even though the partial value is above time;
    // mtie = 0 still clears it
    time_in = 64'h60; tick();
    check("pre_half_mtip", mtip, 1);
    access(1'b1, 2'd0, 32'h0000_FFFF);
    tick();
    check("half_frozen_high", mtip, 1);
    mtie = 1'b0; tick();
    check("half_mtie_clear", mtip, 0);
    mtie = 1'b1; tick();
    check("half_stays_low", mtip, 0);
    access(1'b1, 2'd1, 32'h0);
    tick();
    check("rearm_above_time", mtip, 0);

    // Back-to-back requests
    csr_req = 1'b1; csr_we = 1'b1; csr_sel = 2'd1; csr_wdata = 32'hA5A5_0000;
    tick();
    check("b2b_ack1", csr_ack, 1);
    check("b2b_rdata1", csr_rdata, 32'hA5A5_0000);
    csr_we = 1'b0; csr_sel = 2'd1; csr_wdata = '0;
    tick();
    check("b2b_ack2", csr_ack, 1);
    check("b2b_rdata2", csr_rdata, 32'hA5A5_0000);
    csr_we = 1'b1; csr_sel = 2'd3; csr_wdata = 32'h1234_5678;
    tick();
    check("b2b_ack3", csr_ack, 1);
    check("b2b_rdata3", csr_rdata, 32'h1234_5678);
    csr_req = 1'b0; csr_we = 1'b0; csr_wdata = '0;
    tick();
    check("b2b_ack_end", csr_ack, 0);
    check("b2b_rdata_hold", csr_rdata, 32'h1234_5678);
    access(1'b0, 2'd1, '0);
    check("cmp_hi_after_b2b", csr_rdata, 32'hA5A5_0000);
    access(1'b0, 2'd0, '0);
    check("cmp_lo_after_b2b", csr_rdata, 32'h0000_FFFF);

    // Reset in the middle of an access
    time_in = {64{1'b1}}; tick(); tick();
    check("pre_rst_mtip", mtip, 1);
    csr_req = 1'b1; csr_we = 1'b0; csr_sel = 2'd0;
    @(posedge clk);
    #1;
    csr_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_ack", csr_ack, 0);
    check("midrst_rdata", csr_rdata, 0);
    check("midrst_mtip", mtip, 0);
    tick(); tick();
    rst_n = 1'b1;
    time_in = 64'h1000;
    tick();
    check("postrst_no_ack", csr_ack, 0);
    access(1'b0, 2'd0, '0);
    check("postrst_cmp_lo", csr_rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'd3, '0);
    check("postrst_snap", csr_rdata, 0);
    check("postrst_mtip", mtip, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtimer_compare.md
Name: mtimer_compare

Overview:
- RV32 machine-timer compare and readout block; consumer end of the 64-bit real-time count bus driven by the real-time counter in csr_fin.
- Holds the 64-bit compare register (mtimecmp) behind a 32-bit CSR access port and raises the machine timer interrupt (mtip) when time reaches it.
- Gives the CSR file tear-free 64-bit time reads as two 32-bit halves (time / timeh).

Parameters:
- COUNT_LEN, 64, width of time_in and the compare register; must be 64 (two 32-bit halves).
- CMP_RESET, {COUNT_LEN{1'b1}}, reset value of the compare register; all ones means no interrupt after reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- time_in  input  COUNT_LEN  live real-time count
- mtie  input  1  timer interrupt enable (mie.MTIE)
- csr_req  input  1  access request, single-cycle qualifier
- csr_we  input  1  1 = write, 0 = read; valid with csr_req
- csr_sel  input  2  0 = cmp_lo, 1 = cmp_hi, 2 = time_lo, 3 = time_hi
- csr_wdata  input  32  write data
- csr_rdata  output  32  registered read data, valid with csr_ack
- csr_ack  output  1  one-cycle completion pulse
- mtip  output  1  registered machine timer interrupt pending

Behaviour:
- Reset (async, rst_n low):
  - cmp = CMP_RESET, snap = 0, csr_rdata = 0, csr_ack = 0, mtip = 0, FSM = ARMED.
  - A reset in mid-access drops the pending ack; no ack after reset release.
- Handshake:
  - Every cycle with csr_req = 1 is one access; csr_ack = 1 exactly one cycle later.
  - Back-to-back requests are allowed: req in N and N+1 gives ack in N+1 and N+2.
  - csr_rdata updates only with ack. On writes it returns the written data; otherwise it holds its previous value.
- Writes:
  - sel 0 replaces cmp[31:0]; sel 1 replaces cmp[63:32].
  - sel 2 and sel 3 writes are ignored (time is read-only here) but still acked.
- Reads:
  - sel 0 / 1 return the cmp halves as of the request cycle.
  - sel 2 returns time_in[31:0] and captures snap <= time_in[63:0] in the same cycle.
  - sel 3 returns snap[63:32], not live time. Software reads time_lo then time_hi to get a coherent pair.
  - sel 3 with no prior sel 2 since reset returns 0.
- Compare FSM (two states):
  - ARMED: mtip next = mtie & (time_in >= cmp), unsigned full 64-bit compare; mtip lags time_in/cmp by one cycle.
  - ARMED -> HALF on a cmp_lo write.
  - HALF: mtip frozen at its value from the cycle of the lo write, so a partial compare value cannot raise a spurious interrupt.
  - HALF -> ARMED on a cmp_hi write. Compare resumes with the new full value, and mtip reflects it in the cycle after the ack.
  - A cmp_lo write in HALF stays in HALF and overwrites lo.
  - A cmp_hi write in ARMED stays in ARMED and takes effect immediately.
  - mtie = 0 forces mtip low on the next cycle in ARMED; in HALF, mtie = 0 still clears mtip.
- Level semantics:
  - mtip is level-sensitive and has no ack input.
  - It clears only by raising cmp above time, by mtie = 0, or by time_in wrapping below cmp. At a wrap from all-ones to 0, mtip drops next cycle unless cmp = 0.
- Simultaneous events:
  - time_in changing in the same cycle as a cmp_hi write: the compare uses the new cmp and the current time_in on the following cycle.
  - A time_in jump caused by a counter load is treated like any other value.

Test Plan:
- Reset, then time_in = 0x0000_0000_0000_1000, mtie = 1 -> mtip = 0 (cmp all ones); read sel 0 and sel 1 -> 0xFFFF_FFFF each, ack one cycle after each req.
- Write cmp_lo = 0x0000_0010, then 3 idle cycles, then cmp_hi = 0x0, with time = 0x1000 throughout -> mtip stays 0 while in HALF, and goes 1 the cycle after the cmp_hi ack.
- time_in = 0x0000_0001_FFFF_FFFF: read sel 2 -> 0xFFFF_FFFF; step time_in to 0x0000_0002_0000_0000; read sel 3 -> 0x0000_0001 (snapshot, not live 2).
- cmp = 0x0000_0000_0000_0050, time_in sweeps 0x4E..0x52 -> mtip rises one cycle after time_in = 0x50; drop mtie -> mtip = 0 next cycle.
- Back-to-back reqs in cycles 5, 6, 7 (write sel 1 = 0xA5A5_0000, read sel 1, write sel 3) -> acks in cycles 6, 7, 8; csr_rdata = 0xA5A5_0000 in both cycles 6 and 7; cmp unchanged by the sel 3 write.
- Assert rst_n low the cycle after a req -> no ack, and all outputs read reset values.
